sync_fifo_gen: RTL and testbench

Parametrised synchronous cyclic FIFO, the successor to the fixed 8x16 FIFO. It adds generic width and depth, an optional first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty flags, a fill-level output, a synchronous flush, and sticky error flags. It sits between single-clock producers and consumers in the datapath and is the default buffering element for new blocks.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_ram.sv | 37 +++
 rtl/sync_fifo_gen.sv | 179 +++++++++++++++++
 tb/tb_sync_fifo_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO family.
// Provides the occupancy-step decode used by level counters and the
// default almost-full / almost-empty thresholds, derived from the pointer width.
package fifo_pkg;

  // Direction of the occupancy counter in one cycle
  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_INC  = 2'd1,
    LVL_DEC  = 2'd2
  } lvl_op_e;

  // Default almost-full threshold: two entries below completely full
  function automatic int af_default(input int addr_w);
    return (32'sd1 <<< addr_w) - 32'sd2;
  endfunction

  // Default almost-empty threshold: two entries, clamped for tiny FIFOs
  function automatic int ae_default(input int addr_w);
    return (addr_w >= 32'sd2) ? 32'sd2 : 32'sd1;
  endfunction

  // Accepted write and read in one cycle cancel out, leaving the level unchanged
  function automatic lvl_op_e lvl_op(input logic wr_ok, input logic rd_ok);
    lvl_op_e op;
    case ({wr_ok, rd_ok})
      2'b10:   op = LVL_INC;
      2'b01:   op = LVL_DEC;
      default: op = LVL_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// 1W1R storage array for the synchronous FIFO.
// Synchronous write, asynchronous read; contents are intentionally not reset.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO with optional first-word-fall-through reads,
// programmable almost flags, fill level, synchronous flush and sticky errors.
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-low reset
//   flush           - synchronous clear of pointers, level, rd_valid and pulses
//   wr_en, wr_data  - write request and data
//   rd_en           - read / pop request
//   rd_data         - read data (registered when FWFT=0, fall-through when FWFT=1)
//   rd_valid        - rd_data valid
//   empty, full     - level == 0 / level == DEPTH
//   almost_empty    - level <= AE_LVL
//   almost_full     - level >= AF_LVL
//   level           - current occupancy 0..DEPTH
//   of_pulse        - one-cycle strobe after a rejected write
//   uf_pulse        - one-cycle strobe after a rejected read
//   err_sticky      - latched of/uf condition, cleared by reset or clr_err
//   clr_err         - clears err_sticky (a new error in the same cycle wins)
module sync_fifo_gen
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FWFT   = 0,
  parameter int AF_LVL = af_default(ADDR_W),
  parameter int AE_LVL = ae_default(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              of_pulse,
  output logic              uf_pulse,
  output logic              err_sticky,
  input  logic              clr_err
);

  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LVL_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   AF_THR   = AF_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0]   AE_THR   = AE_LVL[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic [ADDR_W:0]   level_nxt_s;
  logic              of_r;
  logic              uf_r;
  logic              err_r;
  logic              empty_s;
  logic              full_s;
  logic              rd_ok_s;
  logic              wr_ok_s;
  logic              of_cond_s;
  logic              uf_cond_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] mem_rd_data_s;

  assign empty_s   = (level_r == LVL_ZERO);
  assign full_s    = (level_r == LVL_FULL);

  // A read frees a slot in the same cycle, so a write at full is still accepted
  // when paired with an accepted read. A read at empty never sees that write.
  assign rd_ok_s   = rd_en && !empty_s;
  assign wr_ok_s   = wr_en && (!full_s || rd_ok_s);
  assign of_cond_s = wr_en && !wr_ok_s;
  assign uf_cond_s = rd_en && !rd_ok_s;
  assign mem_we_s  = wr_ok_s && !flush;

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_r),
    .wdata (wr_data),
    .raddr (rd_ptr_r),
    .rdata (mem_rd_data_s)
  );

  // Next occupancy from this cycle's accepted operations
  always_comb begin
    level_nxt_s = level_r;
    case (lvl_op(wr_ok_s, rd_ok_s))
      LVL_INC: level_nxt_s = level_r + LVL_ONE;
      LVL_DEC: level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers, level and error strobes; flush overrides any request this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      of_r     <= 1'b0;
      uf_r     <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      of_r     <= 1'b0;
      uf_r     <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
      of_r    <= of_cond_s;
      uf_r    <= uf_cond_s;
    end
  end

  // Sticky error: a new error beats clr_err; a flush cycle raises no error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (!flush && (of_cond_s || uf_cond_s)) begin
      err_r <= 1'b1;
    end else if (clr_err) begin
      err_r <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_W-1:0] rd_data_r;
      logic              rd_valid_r;

      // Registered read port: data captured on an accepted pop, held otherwise
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_data_r  <= {DATA_W{1'b0}};
          rd_valid_r <= 1'b0;
        end else if (flush) begin
          rd_valid_r <= 1'b0;
        end else if (rd_ok_s) begin
          rd_data_r  <= mem_rd_data_s;
          rd_valid_r <= 1'b1;
        end else begin
          rd_valid_r <= 1'b0;
        end
      end

      assign rd_data  = rd_data_r;
      assign rd_valid = rd_valid_r;
    end else begin : g_fwft_read
      // Head word is always displayed; rd_en acknowledges and pops it
      assign rd_data  = mem_rd_data_s;
      assign rd_valid = !empty_s;
    end
  endgenerate

  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_empty = (level_r <= AE_THR);
  assign almost_full  = (level_r >= AF_THR);
  assign level        = level_r;
  assign of_pulse     = of_r;
  assign uf_pulse     = uf_r;
  assign err_sticky   = err_r;

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Directed self-checking bench for sync_fifo_gen: one registered-read instance
// and one first-word-fall-through instance, both DATA_W=8, DEPTH=16.
module tb_sync_fifo_gen;

  logic       clk = 1'b0;
  logic       rst;

  // Registered-read instance signals
  logic       flush, wr_en, rd_en, clr_err;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, empty, full, almost_empty, almost_full;
  logic [4:0] level;
  logic       of_pulse, uf_pulse, err_sticky;

  // FWFT instance signals
  logic       flush1, wr_en1, rd_en1, clr_err1;
  logic [7:0] wr_data1, rd_data1;
  logic       rd_valid1, empty1, full1, almost_empty1, almost_full1;
  logic [4:0] level1;
  logic       of_pulse1, uf_pulse1, err_sticky1;

  int checks   = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  sync_fifo_gen #(.DATA_W(8), .ADDR_W(4), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .level(level), .of_pulse(of_pulse), .uf_pulse(uf_pulse),
    .err_sticky(err_sticky), .clr_err(clr_err)
  );

  sync_fifo_gen #(.DATA_W(8), .ADDR_W(4), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .flush(flush1), .wr_en(wr_en1), .wr_data(wr_data1),
    .rd_en(rd_en1), .rd_data(rd_data1), .rd_valid(rd_valid1), .empty(empty1),
    .full(full1), .almost_empty(almost_empty1), .almost_full(almost_full1),
    .level(level1), .of_pulse(of_pulse1), .uf_pulse(uf_pulse1),
    .err_sticky(err_sticky1), .clr_err(clr_err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    flush1 = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0; clr_err1 = 1'b0; wr_data1 = 8'h00;
    #1;
    check_eq("rst_empty", {31'd0, empty}, 32'd1);
    check_eq("rst_ae", {31'd0, almost_empty}, 32'd1);
    check_eq("rst_full", {31'd0, full}, 32'd0);
    check_eq("rst_af", {31'd0, almost_full}, 32'd0);
    check_eq("rst_level", {27'd0, level}, 32'd0);
    check_eq("rst_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("rst_data", {24'd0, rd_data}, 32'd0);
    check_eq("rst_err", {31'd0, err_sticky}, 32'd0);
    check_eq("rst_fwft_valid", {31'd0, rd_valid1}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      check_eq("fill_level", {27'd0, level}, 32'(i));
      check_eq("fill_af", {31'd0, almost_full}, (i >= 14) ? 32'd1 : 32'd0);
      check_eq("fill_full", {31'd0, full}, (i == 16) ? 32'd1 : 32'd0);
      check_eq("fill_ae", {31'd0, almost_empty}, (i <= 2) ? 32'd1 : 32'd0);
      check_eq("fill_empty", {31'd0, empty}, 32'd0);
    end
    // Overflow write
    wr_data = 8'h77;
    tick();
    check_eq("of_pulse", {31'd0, of_pulse}, 32'd1);
    check_eq("of_err", {31'd0, err_sticky}, 32'd1);
    check_eq("of_level", {27'd0, level}, 32'd16);
    wr_en = 1'b0;
    tick();
    check_eq("of_pulse_drop", {31'd0, of_pulse}, 32'd0);
    check_eq("of_err_hold", {31'd0, err_sticky}, 32'd1);

    // Drain: data arrives one cycle after each rd_en edge
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      tick();
      check_eq("drain_valid", {31'd0, rd_valid}, 32'd1);
      check_eq("drain_data", {24'd0, rd_data}, 32'(i));
      check_eq("drain_level", {27'd0, level}, 32'(16 - i));
    end
    tick();
    check_eq("uf_pulse", {31'd0, uf_pulse}, 32'd1);
    check_eq("uf_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("uf_data_hold", {24'd0, rd_data}, 32'h10);
    check_eq("uf_empty", {31'd0, empty}, 32'd1);
    rd_en = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_eq("clr_err", {31'd0, err_sticky}, 32'd0);
    check_eq("uf_pulse_drop", {31'd0, uf_pulse}, 32'd0);

    // FWFT: word is presented without rd_en, pop clears rd_valid
    wr_en1 = 1'b1; wr_data1 = 8'hA5;
    tick();
    wr_en1 = 1'b0;
    check_eq("fwft_valid", {31'd0, rd_valid1}, 32'd1);
    check_eq("fwft_data", {24'd0, rd_data1}, 32'hA5);
    tick();
    check_eq("fwft_valid_hold", {31'd0, rd_valid1}, 32'd1);
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    check_eq("fwft_pop_valid", {31'd0, rd_valid1}, 32'd0);
    check_eq("fwft_pop_empty", {31'd0, empty1}, 32'd1);
    wr_en1 = 1'b1; wr_data1 = 8'h11;
    tick();
    wr_data1 = 8'h22;
    tick();
    wr_en1 = 1'b0;
    check_eq("fwft_head", {24'd0, rd_data1}, 32'h11);
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    check_eq("fwft_next", {24'd0, rd_data1}, 32'h22);
    check_eq("fwft_level", {27'd0, level1}, 32'd1);

    // Fill again, then sustained simultaneous access across the pointer wrap
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h20 + i);
      q.push_back(wr_data);
      tick();
    end
    check_eq("wrap_full", {31'd0, full}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h40 + k);
      exp_d = q.pop_front();
      q.push_back(wr_data);
      tick();
      check_eq("wrap_data", {24'd0, rd_data}, {24'd0, exp_d});
      check_eq("wrap_valid", {31'd0, rd_valid}, 32'd1);
      check_eq("wrap_level", {27'd0, level}, 32'd16);
      check_eq("wrap_of", {31'd0, of_pulse}, 32'd0);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      exp_d = q.pop_front();
      tick();
      check_eq("wrap_drain", {24'd0, rd_data}, {24'd0, exp_d});
    end
    rd_en = 1'b0;
    check_eq("wrap_empty", {31'd0, empty}, 32'd1);
    check_eq("wrap_err", {31'd0, err_sticky}, 32'd0);

    // Simultaneous at empty: write accepted, read rejected
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    check_eq("emp_both_uf", {31'd0, uf_pulse}, 32'd1);
    check_eq("emp_both_level", {27'd0, level}, 32'd1);
    check_eq("emp_both_valid", {31'd0, rd_valid}, 32'd0);
    tick();
    rd_en = 1'b0;
    check_eq("emp_both_data", {24'd0, rd_data}, 32'h5A);
    check_eq("emp_both_level0", {27'd0, level}, 32'd0);

    // Flush with level 7 and a write on the same edge
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      tick();
    end
    check_eq("pre_flush_level", {27'd0, level}, 32'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    check_eq("flush_level", {27'd0, level}, 32'd0);
    check_eq("flush_empty", {31'd0, empty}, 32'd1);
    check_eq("flush_of", {31'd0, of_pulse}, 32'd0);
    check_eq("flush_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("flush_err_kept", {31'd0, err_sticky}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_eq("flush_clr_err", {31'd0, err_sticky}, 32'd0);

    // Set an error, then assert reset mid-burst at level 9 between edges
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h80 + i);
      tick();
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("burst_level", {27'd0, level}, 32'd9);
    check_eq("burst_err", {31'd0, err_sticky}, 32'd1);
    check_eq("burst_data", {24'd0, rd_data}, 32'h80);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_level", {27'd0, level}, 32'd0);
    check_eq("async_empty", {31'd0, empty}, 32'd1);
    check_eq("async_ae", {31'd0, almost_empty}, 32'd1);
    check_eq("async_data", {24'd0, rd_data}, 32'd0);
    check_eq("async_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("async_err", {31'd0, err_sticky}, 32'd0);
    check_eq("async_fwft_level", {27'd0, level1}, 32'd0);
    wr_en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
